// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N-way select mux.
// Occupancy states, legal N bounds and the select range test.
package mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } mux_state_t;

    localparam int MUX_N_MIN = 2;
    localparam int MUX_N_MAX = 16;

    function automatic logic sel_in_range(
        input logic [31:0] sel,
        input int          n
    );
        return (sel < 32'(n));
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry skid buffer: full throughput with a registered in_ready.
// Main register drives the output; skid absorbs one word under stall.
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    mux_state_t       state_q;
    mux_state_t       state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid_q & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end
            end
            TWO: begin
                // Upstream is stalled here, so in_valid plays no part.
                if (out_fire) begin
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// Pipelined N-way select with valid/ready on both sides.
// Define MUX_SEL_CHECK_EN to build the sticky out-of-range sel_err flag.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic [WIDTH-1:0] word;

    // Out-of-range selects fall through every lane compare and yield 0.
    always_comb begin
        word = '0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    mux_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_data   (word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifdef MUX_SEL_CHECK_EN
    logic sel_err_q;
    logic in_fire;

    assign in_fire = in_valid & in_ready;
    assign sel_err = sel_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (in_fire && !sel_in_range(32'(in_sel), N)) begin
            sel_err_q <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: N=4 main instance, N=3 for range cases.
// sel_err expectations follow MUX_SEL_CHECK_EN.
module tb_mux_nx1_pipe;

    logic         clk = 1'b0;
    logic         reset;

    logic [127:0] in_data4;
    logic [1:0]   in_sel4;
    logic         in_valid4;
    logic         in_ready4;
    logic [31:0]  out_data4;
    logic         out_valid4;
    logic         out_ready4;
    logic         sel_err4;

    logic [95:0]  in_data3;
    logic [1:0]   in_sel3;
    logic         in_valid3;
    logic         in_ready3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic         sel_err3;

    int total  = 0;
    int passed = 0;

`ifdef MUX_SEL_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    mux_nx1_pipe #(.WIDTH(32), .N(4)) u4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data4),
        .in_sel    (in_sel4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sel_err   (sel_err4)
    );

    mux_nx1_pipe #(.WIDTH(32), .N(3)) u3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data3),
        .in_sel    (in_sel3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sel_err   (sel_err3)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane j of pattern i carries {j, i}, so the word identifies its source.
    function automatic logic [31:0] lane(input int j, input int i);
        return {4'(j), 28'(i)};
    endfunction

    function automatic logic [127:0] pack4(input int i);
        return {lane(3, i), lane(2, i), lane(1, i), lane(0, i)};
    endfunction

    initial begin
        reset      = 1'b1;
        in_data4   = '0;
        in_sel4    = '0;
        in_valid4  = 1'b0;
        out_ready4 = 1'b0;
        in_data3   = '0;
        in_sel3    = '0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_out_valid", 64'(out_valid4), 64'd0);
        check("rst_in_ready", 64'(in_ready4), 64'd1);
        check("rst_out_data", 64'(out_data4), 64'd0);
        check("rst_sel_err", 64'(sel_err4), 64'd0);

        // Single word
        in_data4   = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        in_sel4    = 2'd2;
        in_valid4  = 1'b1;
        out_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        check("single_valid", 64'(out_valid4), 64'd1);
        check("single_data", 64'(out_data4), 64'hCCCC0002);
        tick();
        check("single_drain", 64'(out_valid4), 64'd0);

        // Streaming 100 words at full rate
        for (int i = 0; i < 100; i++) begin
            in_data4  = pack4(i);
            in_sel4   = 2'(i % 4);
            in_valid4 = 1'b1;
            tick();
            check("stream_ready", 64'(in_ready4), 64'd1);
            check("stream_valid", 64'(out_valid4), 64'd1);
            check("stream_data", 64'(out_data4), 64'(lane(i % 4, i)));
        end
        in_valid4 = 1'b0;
        tick();
        check("stream_drain", 64'(out_valid4), 64'd0);

        // Backpressure: two accepted, third held off
        out_ready4 = 1'b0;
        in_data4   = pack4(201);
        in_sel4    = 2'd1;
        in_valid4  = 1'b1;
        tick();
        check("bp_ready_one", 64'(in_ready4), 64'd1);
        in_data4 = pack4(202);
        in_sel4  = 2'd3;
        tick();
        check("bp_ready_two", 64'(in_ready4), 64'd0);
        check("bp_hold1", 64'(out_data4), 64'(lane(1, 201)));
        in_data4 = pack4(203);
        in_sel4  = 2'd0;
        tick();
        check("bp_still_full", 64'(in_ready4), 64'd0);
        check("bp_hold_valid", 64'(out_valid4), 64'd1);
        check("bp_hold2", 64'(out_data4), 64'(lane(1, 201)));
        out_ready4 = 1'b1;
        tick();
        check("bp_w2", 64'(out_data4), 64'(lane(3, 202)));
        check("bp_ready_back", 64'(in_ready4), 64'd1);
        tick();
        in_valid4 = 1'b0;
        check("bp_w3", 64'(out_data4), 64'(lane(0, 203)));
        check("bp_w3_valid", 64'(out_valid4), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid4), 64'd0);

        // N=3 out-of-range and in-range selects
        in_data3  = {32'hCCC00002, 32'hBBB00001, 32'hAAA00000};
        in_sel3   = 2'd3;
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        check("oor_valid", 64'(out_valid3), 64'd1);
        check("oor_data", 64'(out_data3), 64'd0);
        check("oor_err", 64'(sel_err3), 64'(ERR_EXP));
        for (int i = 0; i < 10; i++) tick();
        check("oor_sticky", 64'(sel_err3), 64'(ERR_EXP));
        in_sel3   = 2'd2;
        in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        check("n3_sel2", 64'(out_data3), 64'hCCC00002);
        check("n4_no_err", 64'(sel_err4), 64'd0);

        // Reset while full
        out_ready4 = 1'b0;
        in_data4   = pack4(301);
        in_sel4    = 2'd2;
        in_valid4  = 1'b1;
        tick();
        in_data4 = pack4(302);
        tick();
        check("full_before_rst", 64'(in_ready4), 64'd0);
        reset      = 1'b1;
        in_data4   = pack4(303);
        out_ready4 = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid4 = 1'b0;
        check("rst2_valid", 64'(out_valid4), 64'd0);
        check("rst2_ready", 64'(in_ready4), 64'd1);
        check("rst2_data", 64'(out_data4), 64'd0);
        check("rst2_err3", 64'(sel_err3), 64'd0);
        in_data4  = pack4(304);
        in_sel4   = 2'd1;
        in_valid4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        check("post_rst_data", 64'(out_data4), 64'(lane(1, 304)));
        check("post_rst_valid", 64'(out_valid4), 64'd1);
        tick();
        check("no_stale_skid", 64'(out_valid4), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_nx1_pipe.md
Name: mux_nx1_pipe

Overview:
- Parametrised N-way, WIDTH-bit select mux with a registered output stage and a valid/ready handshake on both sides.
- Successor to the combinational 2:1 32-bit mux. Used where the datapath needs a pipelined select: writeback-source select, forwarding select and PC-source select in the pipelined core.
- A 2-entry skid buffer gives full throughput (1 transfer/cycle) with a registered in_ready.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 4, number of inputs; legal range 2..16.
- SEL_W, $clog2(N), select width; derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary select, sampled with in_data.
- in_valid  input  1  upstream offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts this cycle; registered.
- out_data  output  WIDTH  selected word; registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- sel_err  output  1  sticky out-of-range-select flag (see Optional Feature).

Behaviour:
- Transfer rules:
  - In transfer: in_valid & in_ready at a rising edge.
  - Out transfer: out_valid & out_ready at a rising edge.
- Selection: word = in_data[in_sel*WIDTH +: WIDTH] when in_sel < N; otherwise word = 0. The select is resolved at acceptance; only the selected WIDTH bits are stored.
- Storage: main register (drives out_data) and skid register, each with a valid bit.
- State machine, occupancy based:
  - EMPTY: out_valid=0, in_ready=1. In transfer -> word into main -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - In and out together: main <= new word; stay ONE.
    - Out only -> EMPTY.
    - In only: word into skid -> TWO.
  - TWO: out_valid=1, in_ready=0.
    - Out transfer: main <= skid -> ONE.
    - in_valid is ignored.
- Latency: accepted word appears on out_data the cycle after acceptance when the block was EMPTY, or when it was ONE with a simultaneous out transfer.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Stability: out_data and out_valid hold steady while out_valid=1 and out_ready=0.
- in_ready is a pure register output (no combinational path from out_ready). in_ready = (next state != TWO).
- Reset, including mid-operation (any state):
  - Next state EMPTY; out_valid=0, in_ready=1, out_data=0, sel_err=0.
  - Skid contents discarded.
  - Handshakes in the reset cycle are ignored.
- Boundaries:
  - N not a power of two: sel values N..2^SEL_W-1 are out of range and yield 0.
  - N=2: SEL_W=1; behaves as the registered 2:1 mux.

Optional Feature:
- Macro: MUX_SEL_CHECK_EN.
- Defined:
  - An in transfer with in_sel >= N sets sel_err the cycle after acceptance.
  - sel_err stays set until reset.
  - The stored word is still 0.
- Undefined: sel_err tied to 0; no check logic built. Out-of-range selects still yield 0.
- For power-of-two N the check never fires.

Decomposition:
- Package mux_pkg:
  - State enum mux_state_t {EMPTY, ONE, TWO}.
  - Constants MUX_N_MIN=2, MUX_N_MAX=16.
  - Function sel_in_range(sel, n).
- One sub-module: mux_skid_buf.
  - WIDTH-generic 2-entry skid buffer: state machine, main/skid registers and ready logic.
  - mux_nx1_pipe holds the combinational select and sel_err, and instantiates mux_skid_buf.

Test Plan:
- Reset then idle, WIDTH=32, N=4 -> out_valid=0, in_ready=1, out_data=0, sel_err=0.
- Single word: in_data={32'hDDDD0003,32'hCCCC0002,32'hBBBB0001,32'hAAAA0000}, in_sel=2, one-cycle valid, out_ready=1 -> next cycle out_valid=1, out_data=32'hCCCC0002.
- Back-to-back streaming, sel 0,1,2,3 repeated 100 words, out_ready=1 -> one output per cycle, in order, in_ready never drops.
- Backpressure: out_ready=0 while sending 3 words -> in_ready falls after 2 accepted; out_data holds word 1. Then out_ready=1 -> words 1, 2, 3 emerge in order with none lost.
- Out of range, N=3, in_sel=3, MUX_SEL_CHECK_EN defined -> out_data=0, sel_err=1 next cycle and still 1 after 10 cycles. Without the macro -> out_data=0, sel_err=0.
- Reset asserted in state TWO -> next cycle out_valid=0, in_ready=1. First post-reset word emerges alone; stale skid data never appears.
